// File: rtl/reg_scoreboard_pkg.sv
// Shared types and defaults for the register scoreboard (queue of in-flight register writers).
package reg_scoreboard_pkg;

  localparam int unsigned SB_DEPTH_DEF = 4;

  typedef struct packed {
    logic       wen;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  // True when a live entry would write register rs.
  function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] rs);
    return e.wen && (e.rd == rs);
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_queue.sv
// sb_queue: circular buffer of scoreboard entries with push, pop and truncate-to-keep.
module sb_queue
  import reg_scoreboard_pkg::*;
#(
  parameter  int unsigned DEPTH = SB_DEPTH_DEF,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  sb_entry_t                   entry_i,
  input  logic                        pop_i,
  input  logic                        trunc_i,
  input  logic [CW-1:0]               keep_i,
  output sb_entry_t [DEPTH-1:0]       entries_o,
  output logic      [PW-1:0]          head_o,
  output logic      [PW-1:0]          tail_o,
  output logic      [CW-1:0]          count_o
);

  sb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, count_pop;

  // Truncation applies after the pop, so the kept window starts at the new head.
  always_comb begin
    count_pop = count_q - CW'(pop_i);
    head_d    = head_q + PW'(pop_i);
    if (trunc_i) begin
      count_d = (count_pop < keep_i) ? count_pop : keep_i;
      tail_d  = head_d + count_d[PW-1:0];
    end else begin
      count_d = count_pop + CW'(push_i);
      tail_d  = tail_q + PW'(push_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i) mem_q[tail_q] <= entry_i;
    end
  end

  assign entries_o = mem_q;
  assign head_o    = head_q;
  assign tail_o    = tail_q;
  assign count_o   = count_q;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: in-flight writer tracking, source-busy and load-use detection.
// Optional SB_STATS_EN macro enables the saturating stall_cycles counter.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter  int unsigned SB_DEPTH = SB_DEPTH_DEF,
  localparam int unsigned PW       = $clog2(SB_DEPTH),
  localparam int unsigned CW       = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_fire,
  input  logic          id_rd_en,
  input  logic [4:0]    id_rd,
  input  logic          id_is_load,
  input  logic          id_rs1_en,
  input  logic [4:0]    id_rs1,
  input  logic          id_rs2_en,
  input  logic [4:0]    id_rs2,
  input  logic          wb_fire,
  input  logic          flush,
  input  logic [CW-1:0] flush_keep,
  output logic          sb_full,
  output logic          sb_empty,
  output logic [CW-1:0] sb_count,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          load_use_stall,
  output logic [31:0]   stall_cycles
);

  sb_entry_t [SB_DEPTH-1:0] entries;
  sb_entry_t                push_entry, youngest;
  logic [PW-1:0]            head, tail;
  logic [CW-1:0]            count;
  logic                     push, pop, rs1_hit, rs2_hit;

  assign push_entry = '{wen: id_rd_en && (id_rd != 5'd0), rd: id_rd, is_load: id_is_load};
  assign push       = id_fire && !flush && (!sb_full || wb_fire);
  assign pop        = wb_fire && !sb_empty;

  sb_queue #(.DEPTH(SB_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .entry_i   (push_entry),
    .pop_i     (pop),
    .trunc_i   (flush),
    .keep_i    (flush_keep),
    .entries_o (entries),
    .head_o    (head),
    .tail_o    (tail),
    .count_o   (count)
  );

  assign sb_count = count;
  assign sb_full  = (count == CW'(SB_DEPTH));
  assign sb_empty = (count == '0);

  // An entry is live when its offset from head lies inside the current count.
  always_comb begin : busy_scan
    logic [PW-1:0] off;
    off     = '0;
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      off = PW'(i) - head;
      if ({1'b0, off} < count) begin
        if (sb_hit(entries[i], id_rs1)) rs1_hit = 1'b1;
        if (sb_hit(entries[i], id_rs2)) rs2_hit = 1'b1;
      end
    end
  end

  assign rs1_busy = id_rs1_en && (id_rs1 != 5'd0) && rs1_hit;
  assign rs2_busy = id_rs2_en && (id_rs2 != 5'd0) && rs2_hit;

  assign youngest = entries[tail - PW'(1)];

  // Popping the only entry retires the youngest writer this cycle, so no hazard remains.
  assign load_use_stall = !sb_empty && youngest.is_load && !(pop && count == CW'(1)) &&
                          ((id_rs1_en && sb_hit(youngest, id_rs1)) ||
                           (id_rs2_en && sb_hit(youngest, id_rs2)));

`ifdef SB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed vector bench for reg_scoreboard, plus reset and stall-counter sequences.
module tb_reg_scoreboard;

  logic       clk, rst;
  logic       id_fire, id_rd_en, id_is_load, id_rs1_en, id_rs2_en, wb_fire, flush;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic [2:0] flush_keep;
  logic       sb_full, sb_empty, rs1_busy, rs2_busy, load_use_stall;
  logic [2:0] sb_count;
  logic [31:0] stall_cycles;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_stalls = 0;

  typedef struct {
    logic f, rde; logic [4:0] rd; logic ld;
    logic r1e; logic [4:0] r1; logic r2e; logic [4:0] r2;
    logic wb, fl; logic [2:0] keep;
    logic [2:0] cnt; logic full, empty, b1, b2, st;
  } vec_t;

  vec_t tv[$];

  reg_scoreboard #(.SB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .id_fire(id_fire), .id_rd_en(id_rd_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_rs1_en(id_rs1_en), .id_rs1(id_rs1),
    .id_rs2_en(id_rs2_en), .id_rs2(id_rs2), .wb_fire(wb_fire), .flush(flush),
    .flush_keep(flush_keep), .sb_full(sb_full), .sb_empty(sb_empty),
    .sb_count(sb_count), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .load_use_stall(load_use_stall), .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(int f, int rde, int rd, int ld, int r1e, int r1, int r2e, int r2,
                              int wb, int fl, int keep,
                              int cnt, int full, int empty, int b1, int b2, int st);
    vec_t v;
    v.f = 1'(f); v.rde = 1'(rde); v.rd = 5'(rd); v.ld = 1'(ld);
    v.r1e = 1'(r1e); v.r1 = 5'(r1); v.r2e = 1'(r2e); v.r2 = 5'(r2);
    v.wb = 1'(wb); v.fl = 1'(fl); v.keep = 3'(keep);
    v.cnt = 3'(cnt); v.full = 1'(full); v.empty = 1'(empty);
    v.b1 = 1'(b1); v.b2 = 1'(b2); v.st = 1'(st);
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    id_fire = v.f; id_rd_en = v.rde; id_rd = v.rd; id_is_load = v.ld;
    id_rs1_en = v.r1e; id_rs1 = v.r1; id_rs2_en = v.r2e; id_rs2 = v.r2;
    wb_fire = v.wb; flush = v.fl; flush_keep = v.keep;
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs checked 1 unit later.
  task automatic apply(input vec_t v, input int idx);
    drive(v);
    #1;
    chk($sformatf("v%0d.count", idx), sb_count, v.cnt);
    chk($sformatf("v%0d.full", idx), sb_full, v.full);
    chk($sformatf("v%0d.empty", idx), sb_empty, v.empty);
    chk($sformatf("v%0d.rs1_busy", idx), rs1_busy, v.b1);
    chk($sformatf("v%0d.rs2_busy", idx), rs2_busy, v.b2);
    chk($sformatf("v%0d.stall", idx), load_use_stall, v.st);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        f rde rd ld  r1e r1 r2e r2 wb fl kp | cnt fu em b1 b2 st
    tv.push_back(mk(0,0, 0,0, 1, 5,0, 0, 0,0,0, 0,0,1,0,0,0)); // reset state
    tv.push_back(mk(1,1, 5,0, 1, 5,0, 0, 0,0,0, 0,0,1,0,0,0)); // push rd5
    tv.push_back(mk(0,0, 0,0, 1, 5,0, 0, 0,0,0, 1,0,0,1,0,0));
    tv.push_back(mk(0,0, 0,0, 1, 5,0, 0, 1,0,0, 1,0,0,1,0,0)); // retire rd5
    tv.push_back(mk(0,0, 0,0, 1, 5,0, 0, 0,0,0, 0,0,1,0,0,0));
    tv.push_back(mk(1,1, 7,1, 0, 0,1, 7, 0,0,0, 0,0,1,0,0,0)); // push load rd7
    tv.push_back(mk(1,0, 0,0, 0, 0,1, 7, 0,0,0, 1,0,0,0,1,1)); // load-use, push non-writer
    tv.push_back(mk(0,0, 0,0, 0, 0,1, 7, 0,0,0, 2,0,0,0,1,0));
    tv.push_back(mk(1,1, 0,1, 1, 0,0, 0, 0,0,0, 2,0,0,0,0,0)); // push rd0 load
    tv.push_back(mk(0,0, 0,0, 1, 0,1, 0, 0,0,0, 3,0,0,0,0,0));
    tv.push_back(mk(1,1, 9,1, 1, 9,0, 0, 0,0,0, 3,0,0,0,0,0)); // fill to 4
    tv.push_back(mk(0,0, 0,0, 1, 9,1, 7, 0,0,0, 4,1,0,1,1,1));
    tv.push_back(mk(1,1, 3,0, 1, 9,0, 0, 1,0,0, 4,1,0,1,0,1)); // push+pop while full
    tv.push_back(mk(0,0, 0,0, 1, 7,1, 3, 0,0,0, 4,1,0,0,1,0)); // wrapped
    tv.push_back(mk(1,1,11,0, 1,11,0, 0, 0,0,0, 4,1,0,0,0,0)); // dropped push
    tv.push_back(mk(0,0, 0,0, 1,11,0, 0, 0,0,0, 4,1,0,0,0,0));
    tv.push_back(mk(0,0, 0,0, 0, 0,0, 0, 1,0,0, 4,1,0,0,0,0)); // pop to 3
    tv.push_back(mk(1,1,13,0, 1, 3,1, 9, 0,1,2, 3,0,0,1,1,0)); // flush keep 2
    tv.push_back(mk(0,0, 0,0, 1, 3,1, 9, 0,0,0, 2,0,0,0,1,1));
    tv.push_back(mk(0,0, 0,0, 0, 0,1, 9, 1,0,0, 2,0,0,0,1,1));
    tv.push_back(mk(0,0, 0,0, 0, 0,1, 9, 1,1,1, 1,0,0,0,1,0)); // pop youngest + flush keep 1
    tv.push_back(mk(0,0, 0,0, 0, 0,1, 9, 0,0,0, 0,0,1,0,0,0));
    tv.push_back(mk(0,0, 0,0, 0, 0,0, 0, 1,0,0, 0,0,1,0,0,0)); // pop on empty
    tv.push_back(mk(1,1, 4,0, 1, 4,0, 0, 0,0,0, 0,0,1,0,0,0));
    tv.push_back(mk(0,0, 0,0, 1, 4,0, 0, 0,1,4, 1,0,0,1,0,0)); // keep above count
    tv.push_back(mk(0,0, 0,0, 1, 4,0, 0, 0,0,0, 1,0,0,1,0,0));
    tv.push_back(mk(0,0, 0,0, 0, 4,0, 0, 0,0,0, 1,0,0,0,0,0)); // rs1 not enabled

    rst = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.stall_cycles", stall_cycles, 0);

    foreach (tv[i]) begin
      apply(tv[i], i);
      if (tv[i].st) exp_stalls++;
    end
`ifdef SB_STATS_EN
    chk("table.stall_cycles", stall_cycles, exp_stalls);
`else
    chk("table.stall_cycles", stall_cycles, 0);
`endif

    // Grow to three entries, then reset asynchronously mid-cycle.
    drive(mk(1,1,20,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
    @(posedge clk); #1;
    drive(mk(1,1,21,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
    @(posedge clk); #1;
    drive(mk(0,0, 0,0, 1,20,0,0, 0,0,0, 0,0,0,0,0,0));
    #1;
    chk("prerst.count", sb_count, 3);
    chk("prerst.rs1_busy", rs1_busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst.async_count", sb_count, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.count", sb_count, 0);
    chk("rst.empty", sb_empty, 1);
    chk("rst.rs1_busy", rs1_busy, 0);
    chk("rst.stall_cycles", stall_cycles, 0);

    // Three consecutive load-use stall cycles after reset.
    drive(mk(1,1,6,1, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
    @(posedge clk); #1;
    drive(mk(0,0,0,0, 1,6,0,0, 0,0,0, 0,0,0,0,0,0));
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall3.c%0d", k), load_use_stall, 1);
      @(posedge clk); #1;
    end
    id_rs1_en = 1'b0;
    #1;
    chk("stall3.off", load_use_stall, 0);
`ifdef SB_STATS_EN
    chk("stall3.stall_cycles", stall_cycles, 3);
`else
    chk("stall3.stall_cycles", stall_cycles, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
